// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel source / raster output bundle between the timing core and the VGA pins.
interface vga_timing_if #(
   parameter int CH_W  = 1,
   parameter int CNT_W = 10
);
   logic [3*CH_W-1:0] pixel;
   logic [1:0]        mode;
   logic [3*CH_W-1:0] rgb;
   logic              hsync;
   logic              vsync;
   logic [CNT_W-1:0]  hcount;
   logic [CNT_W-1:0]  vcount;
   logic              active;
   logic              pixel_en;
   logic              frame_start;

   modport master (
      input  pixel, mode,
      output rgb, hsync, vsync, hcount, vcount, active, pixel_en, frame_start
   );

   modport slave (
      output pixel, mode,
      input  rgb, hsync, vsync, hcount, vcount, active, pixel_en, frame_start
   );
endinterface

// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA raster engine with sync/DE generation and built-in test patterns.
module vga_timing_core #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 1,
   parameter int CH_W     = 1,
   parameter int CNT_W    = 10,
   parameter int CHK_LOG2 = 5
) (
   input  logic         clk,
   input  logic         rst,
   vga_timing_if.master vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] H_BAR  = CNT_W'(H_ACTIVE / 8);

   logic [DW-1:0]     div;
   logic [1:0]        mode_q;
   logic [1:0]        mode_use;
   logic              tick;
   logic              wrap;
   logic              fs_nxt;
   logic              act_nxt;
   logic              border;
   logic [CNT_W-1:0]  h_nxt;
   logic [CNT_W-1:0]  v_nxt;
   logic [2:0]        bar;
   logic [3*CH_W-1:0] ones;
   logic [3*CH_W-1:0] col;

   // All colour and sync decisions are made for the position the counters move to on this tick,
   // so every registered output describes the same pixel.
   always_comb begin
      tick     = div == DW'(CLK_DIV - 1);
      wrap     = vga.hcount == H_LAST;
      h_nxt    = wrap ? '0 : vga.hcount + CNT_W'(1);
      v_nxt    = wrap ? (vga.vcount == V_LAST ? '0 : vga.vcount + CNT_W'(1)) : vga.vcount;
      fs_nxt   = tick && h_nxt == '0 && v_nxt == '0;
      act_nxt  = h_nxt < H_ACT && v_nxt < V_ACT;
      mode_use = fs_nxt ? vga.mode : mode_q;
      bar      = 3'(h_nxt / H_BAR);
      border   = h_nxt == '0 || h_nxt == H_EDGE || v_nxt == '0 || v_nxt == V_EDGE;
      ones     = '1;
      col      = mode_use == 2'b00 ? vga.pixel :
                 mode_use == 2'b01 ? {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}} :
                 mode_use == 2'b10 ? ((h_nxt[CHK_LOG2] ^ v_nxt[CHK_LOG2]) ? ones : '0) :
                 (border ? ones : vga.pixel);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div             <= '0;
         mode_q          <= 2'b00;
         vga.hcount      <= H_LAST;
         vga.vcount      <= V_LAST;
         vga.hsync       <= !HS_POL;
         vga.vsync       <= !VS_POL;
         vga.active      <= 1'b0;
         vga.rgb         <= '0;
         vga.pixel_en    <= 1'b0;
         vga.frame_start <= 1'b0;
      end else begin
         div             <= tick ? '0 : div + DW'(1);
         vga.pixel_en    <= tick;
         vga.frame_start <= fs_nxt;
         if (tick) begin
            mode_q     <= mode_use;
            vga.hcount <= h_nxt;
            vga.vcount <= v_nxt;
            vga.hsync  <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_POL : !HS_POL;
            vga.vsync  <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_POL : !VS_POL;
            vga.active <= act_nxt;
            vga.rgb    <= act_nxt ? col : '0;
         end
      end
   end
endmodule

// File: doc/vga_timing_core.md
# vga_timing_core

Parametrised VGA raster engine that replaces the fixed 640x480 controller. It generates horizontal and vertical counters, sync pulses with programmable polarity, and a data-enable signal from a configurable timing set, all driven by an internal pixel-clock-enable divider. A per-frame-latched mode selects live-pixel pass-through or one of three built-in test patterns. It sits between the pixel source and the board VGA DAC/pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, asserted level of HSync / VSync (0 = active-low)
- CLK_DIV, 1, clk cycles per pixel tick (>=1)
- CH_W, 1, bits per colour channel; RGB width = 3*CH_W
- CNT_W, 10, counter width; H_TOTAL and V_TOTAL must be <= 2^CNT_W
- CHK_LOG2, 5, log2 of checkerboard square size
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low
- inRGB  in  3*CH_W  live pixel {R,G,B}, sampled on pixel tick
- Mode  in  2  00 pass-through, 01 colour bars, 10 checkerboard, 11 border over inRGB
- HSync / VSync  out  1  sync outputs
- RGB  out  3*CH_W  pixel output, zero outside active area
- HCount / VCount  out  CNT_W  current pixel position
- Active  out  1  high while HCount<H_ACTIVE and VCount<V_ACTIVE
- PixelEn  out  1  one-clk pulse marking each pixel tick
- FrameStart  out  1  one-clk pulse when counters move to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Divider counts 0..CLK_DIV-1; the tick occurs on the clk where the divider equals CLK_DIV-1, and PixelEn is registered high for that edge's following cycle.
- On tick: HCount increments and wraps H_TOTAL-1 -> 0; on wrap, VCount increments and wraps V_TOTAL-1 -> 0.
- HSync is asserted (=HS_POL) for H_ACTIVE+H_FP <= HCount < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise it is !HS_POL. VSync follows the same rule on VCount (490..491).
- Mode is latched into an internal register only on the tick that produces FrameStart. Mid-frame changes are ignored until the next frame.
- Pixel colour, computed for the new position:
  - 00: inRGB.
  - 01: 8 vertical bars of width H_ACTIVE/8. For bar index i, each channel's bits are all set to the corresponding bit of i (R=i[2], G=i[1], B=i[0]).
  - 10: all-ones when HCount[CHK_LOG2]^VCount[CHK_LOG2], else zero.
  - 11: all-ones on the first/last active column and row, else inRGB.
- The RGB register loads the selected colour when the new position is active, and 0 otherwise.

## Timing
- Everything registered. HCount, VCount, HSync, VSync, Active, RGB and FrameStart update together on the tick edge and always describe the same position (no skew between them).
- inRGB sampled at the tick edge appears on RGB for that position (1 tick latency, 0 extra).
- Reset (rst=0 at a clk edge), state after that edge:
  - divider=0, HCount=H_TOTAL-1, VCount=V_TOTAL-1.
  - HSync=!HS_POL, VSync=!VS_POL.
  - Active=0, RGB=0, PixelEn=0, FrameStart=0.
  - latched Mode=00.
- After release, the first tick (CLK_DIV-th edge) moves to (0,0) with FrameStart=1. FrameStart and PixelEn are single-clk pulses regardless of CLK_DIV.
- Reset mid-line or mid-frame has priority over the tick and restores reset values on that edge.
- Outputs hold between ticks when CLK_DIV>1.

## Test plan
- Reset, defaults: hold rst=0 two clks -> HCount=799, VCount=524, HSync=VSync=1, RGB=0. Release -> next edge HCount=0, VCount=0, FrameStart=1 for 1 clk, Active=1.
- Full frame, defaults: count ticks between FrameStart pulses = 420000. Active high for 307200 ticks. HSync low exactly for HCount 656..751 (96 ticks/line). VSync low only on lines 490-491.
- Mode 01, CH_W=1: RGB=000 at HCount 0..79, 001 at 80, 111 at 560..639, 000 at HCount 640 (blanking).
- Mode change mid-frame: switch 00->10 at VCount=100 -> RGB keeps tracking inRGB until the next FrameStart. Then at (32,0) RGB=111 and at (0,0) RGB=000.
- CLK_DIV=2, HS_POL=1: counters advance every second clk, PixelEn high every other clk, HSync high for 656..751.
- Reset asserted at HCount=300, VCount=200 -> next edge reset values. The first post-release tick gives (0,0) with FrameStart.
